// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the multiplexed-display stopwatch.
// Digit radices, seven-segment patterns, FSM states and counter width helpers.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned BLANK_CODE = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_t;

    // Active-high {a,b,c,d,e,f,g}; index 10 is the blank pattern.
    localparam logic [10:0][SEG_W-1:0] SEG_LUT = {
        7'b0000000,  // blank
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    // Tens-of-seconds and tens-of-minutes positions count to 6, the rest to 10.
    function automatic int unsigned digit_radix(input int pos);
        return (pos == 3 || pos == 5) ? 32'd6 : 32'd10;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/stopwatch_mux_display_bcd_digit_cnt.sv
// One BCD digit of the stopwatch count with wrap or hold-at-maximum behaviour.
// at_max is registered alongside the digit so the carry chain reads flops only.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int unsigned RADIX = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    input  logic               hold_max,
    output logic [DIGIT_W-1:0] digit,
    output logic               at_max
);

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(RADIX - 1);

    logic [DIGIT_W-1:0] digit_nx;

    always_comb begin
        digit_nx = digit;
        if (clr) begin
            digit_nx = '0;
        end else if (inc) begin
            if (digit != MAX_VAL) begin
                digit_nx = digit + DIGIT_W'(1);
            end else if (!hold_max) begin
                digit_nx = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit  <= '0;
            at_max <= 1'b0;
        end else begin
            digit  <= digit_nx;
            at_max <= (digit_nx == MAX_VAL);
        end
    end

endmodule

// File: rtl/stopwatch_mux_display.sv
// Stopwatch with start/stop, lap freeze and clear, counting in cascaded BCD digits
// and scanning an N-digit multiplexed seven-segment display with registered pins.
module stopwatch_mux_display
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ   = 1'b1,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_stop,
    input  logic                  lap,
    input  logic                  clear,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [SEG_W-1:0]      segment_out,
    output logic                  dp_out,
    output logic                  running,
    output logic                  overflow
);

    localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned SCAN_DIV = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
    localparam int unsigned PRESC_W  = cnt_width(TICK_DIV);
    localparam int unsigned SCAN_W   = cnt_width(SCAN_DIV);
    localparam int unsigned IDX_W    = cnt_width(NUM_DIGITS);

    sw_state_t state, state_nx;
    logic      frozen, frozen_nx, capture_c;

    logic [PRESC_W-1:0] presc;
    logic               counting_c, tick_c;

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] cnt, frz_val, disp_c;
    logic [NUM_DIGITS-1:0]              at_max, inc_c, blank_c;
    logic                               all_max_c, hold_max_c;

    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic [DIGIT_W-1:0]    sel_digit_c;
    logic [NUM_DIGITS-1:0] sel_onehot_c;
    logic [SEG_W-1:0]      seg_c;
    logic                  dp_c, zero_run;

    // Next state and freeze control; clear beats start_stop beats lap.
    always_comb begin
        state_nx  = state;
        frozen_nx = frozen;
        capture_c = 1'b0;
        if (clear) begin
            state_nx  = IDLE;
            frozen_nx = 1'b0;
        end else if (start_stop) begin
            case (state)
                IDLE: state_nx = RUN;
                RUN:  state_nx = STOP;
                LAP:  state_nx = STOP;
                STOP: begin
                    state_nx  = RUN;
                    frozen_nx = 1'b0;
                end
            endcase
        end else if (lap) begin
            case (state)
                RUN: begin
                    state_nx  = LAP;
                    frozen_nx = 1'b1;
                    capture_c = 1'b1;
                end
                LAP: begin
                    state_nx  = RUN;
                    frozen_nx = 1'b0;
                end
                STOP:    frozen_nx = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            frozen  <= 1'b0;
            running <= 1'b0;
            frz_val <= '0;
        end else begin
            state   <= state_nx;
            frozen  <= frozen_nx;
            running <= (state_nx == RUN) || (state_nx == LAP);
            if (capture_c) begin
                frz_val <= cnt;
            end
        end
    end

    assign counting_c = (state == RUN) || (state == LAP);
    assign tick_c     = counting_c && (presc == PRESC_W'(TICK_DIV - 1));

    // Prescaler holds while stopped so a resume loses no partial tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (counting_c) begin
            presc <= tick_c ? '0 : presc + PRESC_W'(1);
        end
    end

    always_comb begin
        inc_c[0] = tick_c;
        for (int k = 1; k < int'(NUM_DIGITS); k++) begin
            inc_c[k] = inc_c[k-1] && at_max[k-1];
        end
    end

    assign all_max_c  = &at_max;
    assign hold_max_c = !WRAP && all_max_c;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit_cnt #(
            .RADIX(digit_radix(k))
        ) u_digit (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc_c[k]),
            .clr      (clear),
            .hold_max (hold_max_c),
            .digit    (cnt[k]),
            .at_max   (at_max[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (tick_c && all_max_c) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Blank a digit at position 3 or above when it and everything above it is zero.
    always_comb begin
        disp_c   = frozen ? frz_val : cnt;
        zero_run = 1'b1;
        blank_c  = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_run   = zero_run && (disp_c[k] == '0);
            blank_c[k] = BLANK_LZ && (k >= 3) && zero_run;
        end
        sel_digit_c  = disp_c[scan_idx];
        seg_c        = blank_c[scan_idx] ? SEG_LUT[BLANK_CODE] : SEG_LUT[sel_digit_c];
        sel_onehot_c = NUM_DIGITS'(1) << scan_idx;
        dp_c         = (scan_idx == IDX_W'(2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_sel   <= NUM_DIGITS'(1) ^ {NUM_DIGITS{ACTIVE_LOW}};
            segment_out <= SEG_LUT[0] ^ {SEG_W{ACTIVE_LOW}};
            dp_out      <= ACTIVE_LOW;
        end else begin
            digit_sel   <= sel_onehot_c ^ {NUM_DIGITS{ACTIVE_LOW}};
            segment_out <= seg_c ^ {SEG_W{ACTIVE_LOW}};
            dp_out      <= dp_c ^ ACTIVE_LOW;
        end
    end

endmodule
